// File: rtl/fifo_block_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_block_reader_if
// Read-side bus of the 8-deep, 32-bit FIFO as seen by a block reader.
//   rd_en  : pop request (reader -> FIFO), one pop per asserted cycle
//   empty  : FIFO empty flag (FIFO -> reader)
//   rd_ack : pop succeeded, d_out valid this cycle (FIFO -> reader)
//   rd_err : pop issued on the previous cycle failed (FIFO -> reader)
//   d_out  : read data, meaningful only while rd_ack=1 (FIFO -> reader)
// master = the reader, slave = the FIFO.
// ---------------------------------------------------------------------------
interface fifo_block_reader_if;
    logic        rd_en;
    logic        empty;
    logic        rd_ack;
    logic        rd_err;
    logic [31:0] d_out;

    modport master (
        output rd_en,
        input  empty,
        input  rd_ack,
        input  rd_err,
        input  d_out
    );

    modport slave (
        input  rd_en,
        output empty,
        output rd_ack,
        output rd_err,
        output d_out
    );
endinterface

// File: rtl/fifo_block_reader.sv
// ---------------------------------------------------------------------------
// fifo_block_reader
// Pops a requested block of words from a 1-cycle-latency FIFO, accumulates
// their 32-bit sum and pulses done when the block is complete.
//   clk      : system clock, all state changes on the rising edge
//   reset    : synchronous active-high reset
//   start    : single-cycle block request, accepted only in IDLE
//   len      : block length in words (0..8), latched with an accepted start
//   fifo     : FIFO read bus (rd_en out; empty, rd_ack, rd_err, d_out in)
//   busy     : high in READ and DONE
//   done     : one-cycle pulse in the DONE state
//   sum      : block sum, held until the next accepted start
//   word_cnt : words received in the current/last block
//   err_cnt  : rd_err pulses since reset, saturating at 255
// ---------------------------------------------------------------------------
module fifo_block_reader (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [3:0]                 len,
    fifo_block_reader_if.master        fifo,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                sum,
    output logic [3:0]                 word_cnt,
    output logic [7:0]                 err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [3:0]  len_reg;
    logic [3:0]  issued_reg;     // pops in flight or completed for this block
    logic [3:0]  word_cnt_reg;
    logic [31:0] sum_reg;
    logic [7:0]  err_cnt_reg;
    logic        busy_reg;
    logic        done_reg;

    // Pops are gated by issued rather than word_cnt so back-to-back requests
    // can run ahead of the 1-cycle acknowledge without over-reading the block.
    assign fifo.rd_en = (state_reg == READ) && (issued_reg < len_reg) && !fifo.empty;

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sum      = sum_reg;
    assign word_cnt = word_cnt_reg;
    assign err_cnt  = err_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            len_reg      <= 4'd0;
            issued_reg   <= 4'd0;
            word_cnt_reg <= 4'd0;
            sum_reg      <= 32'd0;
            err_cnt_reg  <= 8'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            // Error statistics are kept in every state.
            if (fifo.rd_err && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end

            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_reg      <= len;
                        issued_reg   <= 4'd0;
                        word_cnt_reg <= 4'd0;
                        sum_reg      <= 32'd0;
                        busy_reg     <= 1'b1;
                        if (len == 4'd0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end

                READ: begin
                    // A failed pop gives its slot back so the word is re-requested;
                    // a new pop in the same cycle cancels that out.
                    if (fifo.rd_en && !fifo.rd_err) begin
                        issued_reg <= issued_reg + 4'd1;
                    end else if (!fifo.rd_en && fifo.rd_err) begin
                        issued_reg <= issued_reg - 4'd1;
                    end

                    if (fifo.rd_ack) begin
                        sum_reg      <= sum_reg + fifo.d_out;
                        word_cnt_reg <= word_cnt_reg + 4'd1;
                        if ((word_cnt_reg + 4'd1) == len_reg) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
